// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM encoding and alignment check for the load/store unit.
package load_store_unit_pkg;

    localparam int unsigned SIZE_W = 2;

    // Access size codes; identical to the encoding the data memory decodes.
    typedef enum logic [SIZE_W-1:0] {
        SZ_ILLEGAL = 2'b00,
        SZ_BYTE    = 2'b01,
        SZ_HALF    = 2'b10,
        SZ_WORD    = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Request is rejected for an illegal size or a misaligned address.
    function automatic logic req_error(input size_e size, input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (size)
            SZ_ILLEGAL: err = 1'b1;
            SZ_WORD:    err = (addr_lo != 2'b00);
            SZ_HALF:    err = addr_lo[0];
            default:    err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Sign/zero extension of sub-word load data returned in the low bits.
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  size_e             size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] ext
);

    // Select width, then replicate the sign bit or zero-fill the upper bits.
    always_comb begin
        ext = data;
        case (size)
            SZ_BYTE: ext = is_signed ? {{(DATA_W-8){data[7]}}, data[7:0]}
                                     : {{(DATA_W-8){1'b0}}, data[7:0]};
            SZ_HALF: ext = is_signed ? {{(DATA_W-16){data[15]}}, data[15:0]}
                                     : {{(DATA_W-16){1'b0}}, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, performs a single-cycle memory
// access, and returns an extended, tagged response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_load_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [RD_W-1:0]   req_rd_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [RD_W-1:0]   resp_rd_o,
    output logic              resp_is_load_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic [1:0]        mem_ctrl_read_o,
    output logic [1:0]        mem_ctrl_write_o,
    input  logic [DATA_W-1:0] mem_read_data_i
);

    state_e             state;
    state_e             state_next;
    logic               accept;
    logic               req_err;
    size_e              req_size;

    logic               h_load;
    size_e              h_size;
    logic               h_signed;
    logic [ADDR_W-1:0]  h_addr;
    logic [DATA_W-1:0]  h_wdata;
    logic [RD_W-1:0]    h_rd;
    logic [DATA_W-1:0]  load_ext;

    assign req_size = size_e'(req_size_i);
    assign req_err  = req_error(req_size, req_addr_i[1:0]);

    load_extend #(.DATA_W(DATA_W)) u_extend (
        .data      (mem_read_data_i),
        .size      (h_size),
        .is_signed (h_signed),
        .ext       (load_ext)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state, handshake and memory drive; reset silences everything.
    always_comb begin
        state_next       = state;
        accept           = 1'b0;
        req_ready_o      = 1'b0;
        resp_valid_o     = 1'b0;
        mem_address_o    = '0;
        mem_write_data_o = '0;
        mem_ctrl_read_o  = 2'b00;
        mem_ctrl_write_o = 2'b00;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept     = 1'b1;
                    state_next = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_address_o = h_addr;
                if (h_load) begin
                    mem_ctrl_read_o = h_size;
                end else begin
                    mem_ctrl_write_o = h_size;
                    mem_write_data_o = h_wdata;
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                req_ready_o  = resp_ready_i;
                if (resp_ready_i) begin
                    if (req_valid_i) begin
                        accept     = 1'b1;
                        state_next = req_err ? ST_RESP : ST_ACCESS;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (rst_i) begin
            state_next       = ST_IDLE;
            accept           = 1'b0;
            req_ready_o      = 1'b0;
            resp_valid_o     = 1'b0;
            mem_ctrl_read_o  = 2'b00;
            mem_ctrl_write_o = 2'b00;
        end
    end

    // Request holding registers and registered response payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_load         <= 1'b0;
            h_size         <= SZ_ILLEGAL;
            h_signed       <= 1'b0;
            h_addr         <= '0;
            h_wdata        <= '0;
            h_rd           <= '0;
            resp_data_o    <= '0;
            resp_rd_o      <= '0;
            resp_is_load_o <= 1'b0;
            resp_err_o     <= 1'b0;
        end else begin
            if (accept) begin
                h_load   <= req_load_i;
                h_size   <= req_size;
                h_signed <= req_signed_i;
                h_addr   <= req_addr_i;
                h_wdata  <= req_wdata_i;
                h_rd     <= req_rd_i;
                if (req_err) begin
                    resp_data_o    <= '0;
                    resp_rd_o      <= req_rd_i;
                    resp_is_load_o <= req_load_i;
                    resp_err_o     <= 1'b1;
                end
            end
            if (state == ST_ACCESS) begin
                resp_data_o    <= h_load ? load_ext : '0;
                resp_rd_o      <= h_rd;
                resp_is_load_o <= h_load;
                resp_err_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_load_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [7:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        resp_is_load_o;
    logic        resp_err_o;
    logic [7:0]  mem_address_o;
    logic [31:0] mem_write_data_o;
    logic [1:0]  mem_ctrl_read_o;
    logic [1:0]  mem_ctrl_write_o;
    logic [31:0] mem_read_data_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_load_i       (req_load_i),
        .req_size_i       (req_size_i),
        .req_signed_i     (req_signed_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_rd_i         (req_rd_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_data_o      (resp_data_o),
        .resp_rd_o        (resp_rd_o),
        .resp_is_load_o   (resp_is_load_o),
        .resp_err_o       (resp_err_o),
        .mem_address_o    (mem_address_o),
        .mem_write_data_o (mem_write_data_o),
        .mem_ctrl_read_o  (mem_ctrl_read_o),
        .mem_ctrl_write_o (mem_ctrl_write_o),
        .mem_read_data_i  (mem_read_data_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven from here.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic ld, input logic [1:0] sz, input logic sg,
                             input logic [7:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        req_valid_i  = 1'b1;
        req_load_i   = ld;
        req_size_i   = sz;
        req_signed_i = sg;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        req_rd_i     = rd;
    endtask

    // Full load transaction from IDLE with resp_ready_i high.
    task automatic run_load(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [7:0] addr, input logic [31:0] rdata,
                            input logic [4:0] rd, input logic [31:0] exp);
        drive_req(1'b1, sz, sg, addr, 32'h0, rd);
        #1 chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        step();
        req_valid_i     = 1'b0;
        mem_read_data_i = rdata;
        #1;
        chk({tag, "_ctrl_read"}, 32'(mem_ctrl_read_o), 32'(sz));
        chk({tag, "_addr"}, 32'(mem_address_o), 32'(addr));
        step();
        mem_read_data_i = 32'hDEAD_BEEF;
        #1;
        chk({tag, "_valid"}, 32'(resp_valid_o), 32'd1);
        chk({tag, "_data"}, resp_data_o, exp);
        chk({tag, "_rd"}, 32'(resp_rd_o), 32'(rd));
        chk({tag, "_is_load"}, 32'(resp_is_load_o), 32'd1);
        chk({tag, "_err"}, 32'(resp_err_o), 32'd0);
        step();
    endtask

    // Rejected request: response one cycle after accept, no memory activity.
    task automatic run_err(input string tag, input logic [1:0] sz, input logic [7:0] addr,
                           input logic [4:0] rd);
        drive_req(1'b0, sz, 1'b0, addr, 32'hFFFF_FFFF, rd);
        step();
        req_valid_i = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(resp_valid_o), 32'd1);
        chk({tag, "_err"}, 32'(resp_err_o), 32'd1);
        chk({tag, "_data"}, resp_data_o, 32'd0);
        chk({tag, "_rd"}, 32'(resp_rd_o), 32'(rd));
        chk({tag, "_ctrl"}, 32'({mem_ctrl_read_o, mem_ctrl_write_o}), 32'd0);
        step();
        chk({tag, "_idle_ctrl"}, 32'({mem_ctrl_read_o, mem_ctrl_write_o}), 32'd0);
        chk({tag, "_idle_valid"}, 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_load_i = 1'b0; req_size_i = 2'b00; req_signed_i = 1'b0;
        req_addr_i = 8'h0; req_wdata_i = 32'h0; req_rd_i = 5'h0;
        resp_ready_i = 1'b1; mem_read_data_i = 32'h0;
        step();
        step();
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_data", resp_data_o, 32'd0);
        chk("rst_ctrl", 32'({mem_ctrl_read_o, mem_ctrl_write_o}), 32'd0);
        rst_i = 1'b0;
        #1 chk("idle_ready", 32'(req_ready_o), 32'd1);
        step();

        // Store WORD 0x12345678 at 0x08.
        drive_req(1'b0, 2'b11, 1'b0, 8'h08, 32'h1234_5678, 5'd3);
        step();
        req_valid_i = 1'b0;
        #1;
        chk("st_ctrl_write", 32'(mem_ctrl_write_o), 32'd3);
        chk("st_ctrl_read", 32'(mem_ctrl_read_o), 32'd0);
        chk("st_addr", 32'(mem_address_o), 32'h08);
        chk("st_wdata", mem_write_data_o, 32'h1234_5678);
        chk("st_no_valid", 32'(resp_valid_o), 32'd0);
        step();
        chk("st_valid", 32'(resp_valid_o), 32'd1);
        chk("st_is_load", 32'(resp_is_load_o), 32'd0);
        chk("st_data", resp_data_o, 32'd0);
        chk("st_err", 32'(resp_err_o), 32'd0);
        chk("st_ctrl_done", 32'(mem_ctrl_write_o), 32'd0);
        step();

        // Loads with extension.
        run_load("lb_s", 2'b01, 1'b1, 8'h01, 32'h0000_00F0, 5'd1, 32'hFFFF_FFF0);
        run_load("lb_u", 2'b01, 1'b0, 8'h03, 32'h0000_00F0, 5'd2, 32'h0000_00F0);
        run_load("lh_s", 2'b10, 1'b1, 8'h02, 32'h0000_8001, 5'd4, 32'hFFFF_8001);
        run_load("lh_u", 2'b10, 1'b0, 8'h06, 32'hAAAA_8001, 5'd5, 32'h0000_8001);
        run_load("lw", 2'b11, 1'b1, 8'h04, 32'h9ABC_DEF0, 5'd7, 32'h9ABC_DEF0);

        // Misaligned and illegal-size requests.
        run_err("err_word", 2'b11, 8'h05, 5'd10);
        run_err("err_half", 2'b10, 8'h03, 5'd11);
        run_err("err_size", 2'b00, 8'h00, 5'd12);

        // Backpressure: response held stable while consumer stalls.
        resp_ready_i = 1'b0;
        drive_req(1'b1, 2'b11, 1'b0, 8'h0C, 32'h0, 5'd9);
        step();
        req_valid_i     = 1'b0;
        mem_read_data_i = 32'h1122_3344;
        step();
        for (int i = 0; i < 5; i++) begin
            mem_read_data_i = 32'h5555_0000 + 32'(i);
            #1;
            chk("bp_valid", 32'(resp_valid_o), 32'd1);
            chk("bp_data", resp_data_o, 32'h1122_3344);
            chk("bp_rd", 32'(resp_rd_o), 32'd9);
            chk("bp_ready", 32'(req_ready_o), 32'd0);
            step();
        end
        // Release with a simultaneous store HALFWORD request.
        resp_ready_i = 1'b1;
        drive_req(1'b0, 2'b10, 1'b0, 8'h0A, 32'h0000_BEEF, 5'd2);
        #1 chk("b2b_ready", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        #1;
        chk("b2b_access_valid", 32'(resp_valid_o), 32'd0);
        chk("b2b_ctrl_write", 32'(mem_ctrl_write_o), 32'd2);
        chk("b2b_addr", 32'(mem_address_o), 32'h0A);
        chk("b2b_wdata", mem_write_data_o, 32'h0000_BEEF);
        step();
        chk("b2b_valid", 32'(resp_valid_o), 32'd1);
        chk("b2b_is_load", 32'(resp_is_load_o), 32'd0);
        chk("b2b_rd", 32'(resp_rd_o), 32'd2);
        step();

        // Reset asserted during a store's ACCESS cycle.
        drive_req(1'b0, 2'b11, 1'b0, 8'h10, 32'hCAFE_F00D, 5'd6);
        step();
        req_valid_i = 1'b0;
        rst_i       = 1'b1;
        #1;
        chk("rstmid_ctrl_write", 32'(mem_ctrl_write_o), 32'd0);
        chk("rstmid_ready", 32'(req_ready_o), 32'd0);
        step();
        chk("rstmid_valid", 32'(resp_valid_o), 32'd0);
        chk("rstmid_data", resp_data_o, 32'd0);
        chk("rstmid_rd", 32'(resp_rd_o), 32'd0);
        chk("rstmid_addr", 32'(mem_address_o), 32'd0);
        chk("rstmid_ctrl", 32'({mem_ctrl_read_o, mem_ctrl_write_o}), 32'd0);
        rst_i = 1'b0;
        step();
        chk("rstmid_no_resp", 32'(resp_valid_o), 32'd0);
        chk("rstmid_idle_ready", 32'(req_ready_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
